// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: data width, register index width, writeback source encodings.
package riscv_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
endpackage

// File: rtl/load_scoreboard.sv
// Pending-load vector with set/clear and the decode stall it drives.
// Macro REGFILE_BYPASS_EN: a same-cycle load writeback masks its own pending bit from the stall.
module load_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [1:0]           wb_src,
    input  logic [REG_IDX_W-1:0] wb_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 stall
);
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic [NREGS-1:0] stall_view;
    logic             clr_en;
    logic             do_set;

    assign clr_en = wb_en && (wb_src == RESULT_SRC_LOAD);
    assign do_set = set_en && !flush && (set_idx != '0);

    // Clear is applied before set so a newer load to the same index survives.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[wb_idx] = 1'b0;
        if (do_set)
            pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    always_comb begin
        stall_view = pending;
`ifdef REGFILE_BYPASS_EN
        if (clr_en)
            stall_view[wb_idx] = 1'b0;
`endif
        stall = ((rs1 != '0) && stall_view[rs1]) || ((rs2 != '0) && stall_view[rs2]);
    end
endmodule

// File: rtl/regfile_wb.sv
// RV32I integer register file: W-stage write port, two combinational D-stage read ports, load stall.
// Macro REGFILE_BYPASS_EN: forward a same-cycle writeback onto the read ports.
module regfile_wb #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           RegWriteW,
    input  logic [riscv_pkg::REG_IDX_W-1:0] RdW,
    input  logic [1:0]                     ResultSrcW,
    input  logic [XLEN-1:0]                write_back_result,
    input  logic [riscv_pkg::REG_IDX_W-1:0] Rs1D,
    input  logic [riscv_pkg::REG_IDX_W-1:0] Rs2D,
    output logic [XLEN-1:0]                RD1D,
    output logic [XLEN-1:0]                RD2D,
    input  logic                           LoadIssueE,
    input  logic [riscv_pkg::REG_IDX_W-1:0] RdE,
    input  logic                           FlushE,
    output logic                           StallD
);
    import riscv_pkg::*;

    // Entry 0 exists only to keep indexing simple; it is never written or read.
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (RegWriteW && (RdW != '0)) begin
            regs[RdW] <= write_back_result;
        end
    end

    always_comb begin
        RD1D = (Rs1D == '0) ? '0 : regs[Rs1D];
        RD2D = (Rs2D == '0) ? '0 : regs[Rs2D];
`ifdef REGFILE_BYPASS_EN
        if (RegWriteW && (RdW != '0) && (RdW == Rs1D))
            RD1D = write_back_result;
        if (RegWriteW && (RdW != '0) && (RdW == Rs2D))
            RD2D = write_back_result;
`endif
    end

    load_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (LoadIssueE),
        .set_idx (RdE),
        .flush   (FlushE),
        .wb_en   (RegWriteW),
        .wb_src  (ResultSrcW),
        .wb_idx  (RdW),
        .rs1     (Rs1D),
        .rs2     (Rs2D),
        .stall   (StallD)
    );
endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;
    logic [31:0] write_back_result;
    logic [4:0]  Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D;
    logic        LoadIssueE;
    logic [4:0]  RdE;
    logic        FlushE;
    logic        StallD;

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_wb dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
        .write_back_result(write_back_result), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
        .LoadIssueE(LoadIssueE), .RdE(RdE), .FlushE(FlushE), .StallD(StallD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; RegWriteW = 0; RdW = 0; ResultSrcW = 2'b00; write_back_result = 0;
        LoadIssueE = 0; RdE = 0; FlushE = 0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] v);
        RegWriteW = 1; RdW = rd; ResultSrcW = src; write_back_result = v;
    endtask

    initial begin
        idle(); Rs1D = 0; Rs2D = 0;
        // preload junk then reset on top of it
        wb(5'd12, 2'b00, 32'hFFFF_FFFF); LoadIssueE = 1; RdE = 5'd12;
        tick();
        idle(); rst = 1;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            Rs1D = 5'(i); Rs2D = 5'(31 - i); #1;
            chk($sformatf("rst_rd1_x%0d", i), RD1D, 32'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - i), RD2D, 32'h0);
            chk($sformatf("rst_stall_%0d", i), {31'b0, StallD}, 32'h0);
        end

        // basic write then read
        wb(5'd5, 2'b00, 32'hDEAD_BEEF); Rs1D = 5; Rs2D = 0; #1;
        chk("x5_same_cycle", RD1D, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick(); idle(); #1;
        chk("x5_next_cycle", RD1D, 32'hDEAD_BEEF);

        // x0 hardwired
        wb(5'd0, 2'b00, 32'h1234_5678); Rs1D = 0; Rs2D = 0; #1;
        chk("x0_same_rd1", RD1D, 32'h0);
        chk("x0_same_rd2", RD2D, 32'h0);
        tick(); idle(); #1;
        chk("x0_after", RD1D, 32'h0);

        // same-cycle write forwarding on both ports
        wb(5'd7, 2'b10, 32'h1111_1111); tick(); idle();
        wb(5'd7, 2'b00, 32'hA5A5_A5A5); Rs1D = 7; Rs2D = 7; #1;
        chk("x7_byp_rd1", RD1D, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        chk("x7_byp_rd2", RD2D, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        tick(); idle(); #1;
        chk("x7_rd1", RD1D, 32'hA5A5_A5A5);
        chk("x7_rd2", RD2D, 32'hA5A5_A5A5);

        // load to x9, held on Rs2D
        Rs1D = 0; Rs2D = 9; LoadIssueE = 1; RdE = 9; #1;
        chk("ld9_issue_cycle", {31'b0, StallD}, 32'h0);
        tick(); idle(); #1;
        chk("ld9_pend1", {31'b0, StallD}, 32'h1);
        tick(); #1;
        chk("ld9_pend2", {31'b0, StallD}, 32'h1);
        wb(5'd9, 2'b01, 32'hCAFE_F00D); #1;
        chk("ld9_wb_stall", {31'b0, StallD}, BYP ? 32'h0 : 32'h1);
        chk("ld9_wb_rd2", RD2D, BYP ? 32'hCAFE_F00D : 32'h0);
        tick(); idle(); #1;
        chk("ld9_after_stall", {31'b0, StallD}, 32'h0);
        chk("ld9_after_rd2", RD2D, 32'hCAFE_F00D);

        // flushed load never sets pending
        Rs2D = 0; LoadIssueE = 1; RdE = 3; FlushE = 1;
        tick(); idle(); Rs1D = 3; #1;
        chk("ld3_flushed", {31'b0, StallD}, 32'h0);

        // set and clear of x3 in the same cycle: newer load wins
        LoadIssueE = 1; RdE = 3;
        tick(); idle(); #1;
        chk("ld3_pend", {31'b0, StallD}, 32'h1);
        LoadIssueE = 1; RdE = 3; wb(5'd3, 2'b01, 32'h0000_0033); #1;
        chk("ld3_setclr_cycle", {31'b0, StallD}, BYP ? 32'h0 : 32'h1);
        tick(); idle(); #1;
        chk("ld3_still_pend", {31'b0, StallD}, 32'h1);
        wb(5'd3, 2'b01, 32'h0000_0333);
        tick(); idle(); #1;
        chk("ld3_cleared", {31'b0, StallD}, 32'h0);
        chk("ld3_value", RD1D, 32'h0000_0333);

        // non-load writeback leaves pending alone
        LoadIssueE = 1; RdE = 4; Rs1D = 4;
        tick(); idle();
        wb(5'd4, 2'b00, 32'h0000_0044); #1;
        chk("ld4_alu_wb_cycle", {31'b0, StallD}, 32'h1);
        tick(); idle(); #1;
        chk("ld4_alu_wb_after", {31'b0, StallD}, 32'h1);

        // set x6 while clearing x4
        LoadIssueE = 1; RdE = 6; wb(5'd4, 2'b01, 32'h0000_0444);
        tick(); idle(); Rs1D = 4; Rs2D = 0; #1;
        chk("ld4_cleared", {31'b0, StallD}, 32'h0);
        Rs1D = 0; Rs2D = 6; #1;
        chk("ld6_set", {31'b0, StallD}, 32'h1);

        // reset beats a simultaneous write and set
        rst = 1; wb(5'd5, 2'b00, 32'h5555_5555); LoadIssueE = 1; RdE = 8;
        tick(); idle(); Rs1D = 5; Rs2D = 6; #1;
        chk("rst_mid_x5", RD1D, 32'h0);
        chk("rst_mid_stall6", {31'b0, StallD}, 32'h0);
        Rs2D = 8; #1;
        chk("rst_mid_stall8", {31'b0, StallD}, 32'h0);
        wb(5'd6, 2'b01, 32'h0000_0066);
        tick(); idle(); Rs1D = 6; Rs2D = 0; #1;
        chk("rst_late_wb6", RD1D, 32'h0000_0066);
        chk("rst_late_stall", {31'b0, StallD}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Integer register file written by the writeback stage and read by the decode stage of the 5-stage RV32I pipeline. It takes the selected writeback result with its destination index and write enable, and serves two combinational read ports to ID. A small load scoreboard tracks registers with an outstanding load in EX/MEM. From that scoreboard the block raises a decode stall when a source operand is not yet available.

## Interface
Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count. x0 is hardwired to zero.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock. All state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- RegWriteW  in  1  writeback write enable.
- RdW  in  5  writeback destination index.
- ResultSrcW  in  2  writeback source select. 2'b01 means load data.
- write_back_result  in  XLEN  value to be written.
- Rs1D  in  5  decode source index 1.
- Rs2D  in  5  decode source index 2.
- RD1D  out  XLEN  read data for Rs1D.
- RD2D  out  XLEN  read data for Rs2D.
- LoadIssueE  in  1  a load instruction is in EX this cycle and advances.
- RdE  in  5  destination index of that load.
- FlushE  in  1  the EX instruction is squashed this cycle.
- StallD  out  1  a decode source has a pending load.

## Operation
Register array:
- The array is x1..x31, XLEN bits each.
- On a rising edge with RegWriteW=1 and RdW!=0, regs[RdW] <= write_back_result.
- RdW=0 writes are dropped.
- Reads are combinational. RDnD = 0 when RsnD=0, otherwise regs[RsnD].
- With the bypass feature compiled in (see Configuration), a same-cycle write to the read index is forwarded:
  - If RegWriteW, RdW==RsnD and RdW!=0, then RDnD = write_back_result.
  - The two ports are evaluated independently. Rs1D==Rs2D==RdW forwards on both ports.

Load scoreboard:
- The scoreboard is a 32-bit pending vector. Bit 0 is forced to 0.
- Set: when LoadIssueE=1, FlushE=0 and RdE!=0, set pending[RdE].
- Clear: when RegWriteW=1 and ResultSrcW==2'b01, clear pending[RdW].
- A set and a clear of the same index in the same cycle leaves the bit set, because the newer load wins.
- A set and a clear of different indices in the same cycle both take effect.
- StallD = (Rs1D!=0 and pending[Rs1D]) or (Rs2D!=0 and pending[Rs2D]).
- With bypass compiled in, a clear of index i in the current cycle also masks pending[i] from StallD in that cycle. The forwarded value is valid, so there is no stall.
- A non-load writeback (ResultSrcW != 01) never clears a pending bit.

## Timing
- Write latency: the write is visible from the stored array one cycle after the RegWriteW edge. With bypass, it is visible in the same cycle.
- Read latency: 0 cycles, fully combinational from Rs1D, Rs2D and the array.
- StallD is combinational from the index inputs and the pending vector. It asserts the cycle after the load issues to EX, and holds until the load writes back in W.
- Reset: on a rising edge with rst=1:
  - all registers become 0 and pending becomes all zeros;
  - RD1D, RD2D and StallD therefore read 0 in the following cycle;
  - rst has priority over any simultaneous write, set or clear.
- Reset mid-load: the pending bit is dropped. A later load writeback of that index still writes the array; its clear is harmless.

## Configuration
- REGFILE_BYPASS_EN defined:
  - same-cycle W-to-D forwarding on both read ports;
  - StallD is masked by the same-cycle load clear.
- REGFILE_BYPASS_EN undefined:
  - reads return only stored contents;
  - StallD deasserts one cycle after the load writeback.
  - The hazard unit must therefore tolerate the extra stall cycle.

## Structure
- Shared package riscv_pkg holds:
  - XLEN and REG_IDX_W=5;
  - RESULT_SRC_ALU=2'b00, RESULT_SRC_LOAD=2'b01 and RESULT_SRC_PC4=2'b10.
- One sub-module, load_scoreboard, contains the pending vector together with its set, clear and stall logic.
- The top level holds the array, the read muxing and the bypass.

## Test plan
- Reset, then read all indices: every RD1D and RD2D value is 0 and StallD=0.
- Write x5=0xDEADBEEF with RegWriteW=1, then read Rs1D=5 next cycle: RD1D=0xDEADBEEF.
- Write x0=0x12345678: a read of x0 returns 0.
- Same-cycle write x7=0xA5A5A5A5 with Rs1D=Rs2D=7:
  - with REGFILE_BYPASS_EN, both ports read 0xA5A5A5A5;
  - without it, both ports return the old value.
- Issue a load with RdE=9, then hold Rs2D=9:
  - StallD=1 until the writeback with ResultSrcW=01 and RdW=9;
  - StallD=0 in that cycle with bypass, or one cycle later without it.
- Load to x3 with FlushE=1: StallD stays 0.
- Load to x3 set in the same cycle as the x3 load clear: the bit stays pending and StallD=1 for Rs1D=3.
